// File: rtl/bitxor_seq.sv
// -----------------------------------------------------------------------------
// bitxor_seq
//   Upstream controller for the end-point register stage. It accepts an
//   operand pair (A, B) and runs one operation at a time:
//     CLEAR : inst=01 for one cycle
//     LOAD  : inst=10 for WIDTH cycles, streaming A LSB first
//     XOR   : inst=11 for WIDTH cycles, streaming B LSB first
//     DRAIN : inst=00 for LAT cycles (absent when LAT=0)
//     DONE  : holds the collected result until it is consumed
//   The ltorxor bit that belongs to each XOR cycle is captured LAT cycles
//   later into the next result bit, starting at bit 0.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   reset      : synchronous, active-low reset
//   in_valid   : operand pair valid
//   in_ready   : block can accept an operand pair
//   in_a       : operand A (WIDTH bits), shifted out first
//   in_b       : operand B (WIDTH bits), XORed against A
//   inst       : instruction to downstream (00 hold, 01 clear, 10 shift, 11 xor)
//   ztonxor    : serial data bit accompanying inst
//   ltorxor    : serial result bit returned from downstream
//   out_valid  : out_result valid
//   out_ready  : consumer accepts out_result
//   out_result : collected result (WIDTH bits), bit i = i-th captured bit
//   busy       : high whenever the controller is not idle
//   out_parity : XOR-reduce of out_result while out_valid, else 0
//                (present only when BITXOR_SEQ_PARITY_EN is defined)
//
// Optional feature macro: BITXOR_SEQ_PARITY_EN
//
// Every output is a register. Output registers are loaded from the state
// seen during the previous cycle, so the value driven on inst/ztonxor lags
// the state register by one cycle. in_ready and out_valid are the exception
// on the handshake edge itself: they drop at once so a second transfer can
// never be sampled on the following edge.
// -----------------------------------------------------------------------------
module bitxor_seq #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [1:0]       inst,
  output logic             ztonxor,
  input  logic             ltorxor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
`ifdef BITXOR_SEQ_PARITY_EN
  output logic             out_parity,
`endif
  output logic             busy
);

  localparam int CW    = $clog2(WIDTH) + 1;
  localparam int LATM1 = (LAT > 0) ? (LAT - 1) : 0;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAT_LAST = CW'(LATM1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_XOR   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [1:0] INST_HOLD  = 2'b00;
  localparam logic [1:0] INST_CLEAR = 2'b01;
  localparam logic [1:0] INST_SHIFT = 2'b10;
  localparam logic [1:0] INST_XOR   = 2'b11;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cap_idx_q, cap_idx_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       inst_q, inst_d;
  logic             ztonxor_q, ztonxor_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             accept;
  logic             out_hs;
  logic             cap_en;
  logic [WIDTH-1:0] cap_hit;

  assign accept = (state_q == S_IDLE) && in_valid && in_ready_q;
  assign out_hs = out_valid_q && out_ready;

  // ---------------------------------------------------------------------------
  // Capture timing: the bit answering an XOR instruction that is on the inst
  // output now becomes valid LAT cycles later. With LAT=0 the downstream
  // answer is combinational and is taken on the edge that ends the XOR cycle.
  // ---------------------------------------------------------------------------
  generate
    if (LAT == 0) begin : g_lat0
      assign cap_en = (inst_q == INST_XOR);
    end else begin : g_latn
      logic [LAT-1:0] xv_q, xv_d;

      always_comb begin
        xv_d    = xv_q << 1;
        xv_d[0] = (inst_q == INST_XOR);
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          xv_q <= '0;
        end else begin
          xv_q <= xv_d;
        end
      end

      assign cap_en = xv_q[LAT-1];
    end
  endgenerate

  // One-hot select of the result bit being written this cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_hit
      assign cap_hit[gi] = cap_en && (cap_idx_q == CW'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_idx_d = cap_idx_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    result_d  = (result_q & ~cap_hit) | (cap_hit & {WIDTH{ltorxor}});

    // Capture index saturates at the top bit.
    if (cap_en && (cap_idx_q != CNT_LAST)) begin
      cap_idx_d = cap_idx_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_sh_d  = in_a;
          b_sh_d  = in_b;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        result_d  = '0;
        cap_idx_d = '0;
        cnt_d     = '0;
        state_d   = S_LOAD;
      end
      S_LOAD: begin
        a_sh_d = a_sh_q >> 1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_XOR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_XOR: begin
        b_sh_d = b_sh_q >> 1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = (LAT == 0) ? S_DONE : S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_hs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    inst_d    = INST_HOLD;
    ztonxor_d = 1'b0;
    case (state_q)
      S_CLEAR: inst_d = INST_CLEAR;
      S_LOAD: begin
        inst_d    = INST_SHIFT;
        ztonxor_d = a_sh_q[0];
      end
      S_XOR: begin
        inst_d    = INST_XOR;
        ztonxor_d = b_sh_q[0];
      end
      default: begin
        inst_d    = INST_HOLD;
        ztonxor_d = 1'b0;
      end
    endcase

    in_ready_d  = (state_q == S_IDLE) && !accept;
    out_valid_d = (state_q == S_DONE) && !out_hs;
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cap_idx_q   <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      result_q    <= '0;
      inst_q      <= INST_HOLD;
      ztonxor_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_idx_q   <= cap_idx_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      result_q    <= result_d;
      inst_q      <= inst_d;
      ztonxor_q   <= ztonxor_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef BITXOR_SEQ_PARITY_EN
  logic parity_q, parity_d;

  // Parity tracks the value that out_result will hold next cycle, so it is
  // valid on the very edge out_valid rises.
  always_comb begin
    parity_d = out_valid_d ? (^result_d) : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

  assign in_ready   = in_ready_q;
  assign inst       = inst_q;
  assign ztonxor    = ztonxor_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bitxor_seq.sv
// -----------------------------------------------------------------------------
// tb_bitxor_seq
//   Bench for bitxor_seq (WIDTH=8, LAT=1) with an ideal downstream register
//   stage. Expected results are pushed into a queue when an operand pair is
//   issued; a monitor pops and compares whenever a result is handed over.
// -----------------------------------------------------------------------------
module tb_bitxor_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   inst;
  logic         ztonxor;
  logic         ltorxor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         busy;
`ifdef BITXOR_SEQ_PARITY_EN
  logic         out_parity;
`endif

  bitxor_seq #(.WIDTH(W), .LAT(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .inst       (inst),
    .ztonxor    (ztonxor),
    .ltorxor    (ltorxor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
`ifdef BITXOR_SEQ_PARITY_EN
    .out_parity (out_parity),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal downstream stage with one register of latency on ltorxor.
  logic [W-1:0] ds_store = '0;
  logic         ds_out   = 1'b0;
  always @(posedge clk) begin
    case (inst)
      2'b01: ds_store <= '0;
      2'b10: ds_store <= {ztonxor, ds_store[W-1:1]};
      2'b11: begin
        ds_out   <= ds_store[0] ^ ztonxor;
        ds_store <= ds_store >> 1;
      end
      default: ;
    endcase
  end
  assign ltorxor = ds_out;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];   // {parity, result}
  logic [W:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: a result is handed over on the next edge when both are high.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h, expected no result", out_result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {24'd0, out_result}, {24'd0, mon_e[W-1:0]});
`ifdef BITXOR_SEQ_PARITY_EN
        chk("parity", {31'd0, out_parity}, {31'd0, mon_e[W]});
`endif
        $display("txn cycle=%0d result=%02h expected=%02h", cyc, out_result, mon_e[W-1:0]);
      end
    end
  end

  // Present an operand pair, wait (bounded) for acceptance, push expectation.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push, input logic [W:0] e, output int acc);
    int n;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
    if (push) exp_q.push_back(e);
    $display("issue cycle=%0d a=%02h b=%02h", acc, a, b);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", {31'd0, (n < 200)}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    logic [W-1:0] av;
    logic [W-1:0] bv;

    reset     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'hA5;
    in_b      = 8'h3C;
    out_ready = 1'b0;

    // Reset held for two cycles with in_valid high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inst", {30'd0, inst}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", {24'd0, out_result}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef BITXOR_SEQ_PARITY_EN
    chk("rst_parity", {31'd0, out_parity}, 32'd0);
`endif
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    chk("rst_no_accept", {31'd0, busy}, 32'd0);

    // Single op with output backpressure.
    av = 8'hA5;
    bv = 8'h3C;
    do_op(av, bv, 1'b1, {1'b0, 8'h99}, acc);
    @(negedge clk);
    chk("in_ready_drop", {31'd0, in_ready}, 32'd0);
    chk("busy_high", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("inst_clear", {30'd0, inst}, 32'd1);
      end else if (i <= 9) begin
        chk("inst_load", {30'd0, inst}, 32'd2);
        chk("z_load", {31'd0, ztonxor}, {31'd0, av[i-2]});
      end else begin
        chk("inst_xor", {30'd0, inst}, 32'd3);
        chk("z_xor", {31'd0, ztonxor}, {31'd0, bv[i-10]});
      end
    end
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", cyc - acc, 32'd19);
    chk("first_result", {24'd0, out_result}, 32'h99);
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_out_result", {24'd0, out_result}, 32'h99);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hs_out_valid", {31'd0, out_valid}, 32'd0);
    chk("hs_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("hs_in_ready_high", {31'd0, in_ready}, 32'd1);

    // Reset during the fourth LOAD cycle, then a fresh op.
    do_op(8'h12, 8'h34, 1'b0, '0, acc);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_inst", {30'd0, inst}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b1;
    do_op(8'hFF, 8'h0F, 1'b1, {1'b0, 8'hF0}, acc);
    wait_done();

    // in_valid / in_a toggled during XOR must be ignored.
    do_op(8'h5A, 8'h66, 1'b1, {1'b0, 8'h3C}, acc);
    repeat (10) @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_a     = 8'hFF;
    in_b     = 8'h00;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("ign_in_ready", {31'd0, in_ready}, 32'd0);
      in_a = ~in_a;
    end
    in_valid = 1'b0;
    wait_done();

    // Parity vectors (results are also checked without the feature).
    do_op(8'h01, 8'h00, 1'b1, {1'b1, 8'h01}, acc);
    wait_done();
    do_op(8'h03, 8'h00, 1'b1, {1'b0, 8'h03}, acc);
    wait_done();

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitxor_seq.md
Name: bitxor_seq

Overview:
- Upstream controller for the end-point register stage.
- Accepts an operand pair (A, B) over a valid/ready handshake.
- Drives the 2-bit instruction and serial ztonxor bit stream into the downstream stage, and collects the returned ltorxor bits into a parallel result.
- Presents the result on a valid/ready output; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- LAT, 1, cycles from an XOR instruction being driven to its ltorxor bit being valid at this block's input; legal range 0..3.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A, shifted out first, LSB first.
- in_b  input  WIDTH  operand B, XORed against A, LSB first.
- inst  output  2  instruction to downstream stage: 00 hold, 01 clear, 10 shift-in, 11 xor.
- ztonxor  output  1  serial data bit accompanying inst.
- ltorxor  input  1  serial result bit returned from downstream stage.
- out_valid  output  1  out_result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  collected result, bit i = i-th captured ltorxor.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is sampled on the rising clk edge while reset==0. It overrides everything, including mid-operation.
- Reset values: state=IDLE, inst=00, ztonxor=0, in_ready=1, out_valid=0, out_result=0, busy=0, all counters 0.
- All outputs are registered.
- States: IDLE, CLEAR, LOAD, XOR, DRAIN, DONE.
- IDLE:
  - in_ready=1, inst=00.
  - On in_valid && in_ready: latch in_a/in_b into shift registers, go to CLEAR.
  - in_ready drops in the next cycle.
- CLEAR: 1 cycle; inst=01, ztonxor=0; clears the result register. Then LOAD.
- LOAD: WIDTH cycles; inst=10, ztonxor=A[k] for k=0..WIDTH-1. Then XOR.
- XOR:
  - WIDTH cycles; inst=11, ztonxor=B[k].
  - The ltorxor bit is captured LAT cycles after each XOR cycle into result bit k.
  - The capture index counts from 0 and stops at WIDTH-1.
- DRAIN:
  - LAT cycles, skipped when LAT=0; inst=00, ztonxor=0.
  - Remaining captures complete here. Then DONE.
- DONE:
  - out_valid=1, out_result stable, inst=00.
  - On out_ready: out_valid=0, go to IDLE with in_ready=1 the following cycle.
  - out_ready high on the same edge out_valid first rises still holds out_valid for that cycle. The result is consumed on the next sampled edge where both are high.
- in_valid outside IDLE is ignored; no operand is lost because in_ready=0.
- in_a/in_b changes after acceptance have no effect.
- Total latency from acceptance to out_valid: 1 + WIDTH + WIDTH + LAT + 1 cycles.
  - WIDTH=8, LAT=1 gives 19.
- Back-to-back operation: a new operand is accepted at the earliest 1 cycle after the out handshake.
- Counters are sized ceil(log2(WIDTH))+1 bits. No wrap is reachable within an operation.

Optional Feature:
- Macro BITXOR_SEQ_PARITY_EN.
- When defined, add output out_parity (1 bit) equal to the XOR-reduce of out_result.
  - Valid together with out_valid; 0 at reset and whenever out_valid=0.
- When undefined, the port does not exist and behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> inst=00, in_ready=1, out_valid=0, out_result=0, busy=0; no acceptance.
- Single op, WIDTH=8, LAT=1, ideal downstream model: A=8'hA5, B=8'h3C.
  - Expected inst sequence: 01 x1, 10 x8 with ztonxor=1,0,1,0,0,1,0,1, then 11 x8.
  - out_valid rises 19 cycles after acceptance with out_result=8'h99.
- Output backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_result stays 8'h99, in_ready stays 0. out_ready=1 -> out_valid=0 next cycle, in_ready=1 the cycle after.
- Mid-op reset: assert reset=0 during the 4th LOAD cycle -> next cycle state IDLE, inst=00, busy=0. New op A=8'hFF, B=8'h0F -> out_result=8'hF0.
- Ignored input: toggle in_valid and in_a during XOR -> no second acceptance; the result reflects the original operands only.
- Parity (BITXOR_SEQ_PARITY_EN defined): A=8'h01, B=8'h00 -> out_result=8'h01, out_parity=1. A=8'h03, B=8'h00 -> out_parity=0.
